branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//  Direction predictor and redirect/flush sequencer for conditional branches in the 5-stage core.
//  - ID: predicts B-type branches from a 2-bit saturating-counter table and redirects fetch on predict-taken.
//  - EX: consumes the branch ALU outcome, detects mispredicts, redirects the PC and squashes younger stages.
//  - EX: trains the table and keeps 32-bit branch/mispredict performance counters.
// PARAMETERS
//  BHT_ENTRIES  16  counter-table depth, power of 2; IDX = log2(BHT_ENTRIES)
//  CNT_INIT     1   reset value of every 2-bit counter (01 = weakly not-taken)
// PORTS
//  CLK            in   1   clock, all state updates on rising edge
//  RSTn           in   1   asynchronous, active-low reset
//  stall          in   1   pipeline hold; freezes ID/EX consumption this cycle
//  id_valid       in   1   ID holds a real instruction
//  id_is_btype    in   1   ID instruction is B-type
//  id_pc          in   32  PC of ID instruction
//  id_target      in   32  id_pc + B-immediate
//  id_pred_taken  out  1   prediction for ID instruction; carried down the pipe to EX
//  ex_valid       in   1   EX holds a real instruction
//  ex_is_btype    in   1   EX instruction is B-type
//  ex_pc          in   32  PC of EX instruction
//  ex_target      in   32  ex_pc + B-immediate
//  ex_taken       in   1   branch ALU result (already gated by B-type)
//  ex_pred_taken  in   1   prediction carried from ID
//  redirect_valid out  1   load PC from redirect_pc this cycle
//  redirect_pc    out  32  next fetch PC
//  flush_ifid     out  1   squash IF/ID register
//  flush_idex     out  1   squash ID/EX register
//  branch_cnt     out  32  resolved B-type count
//  mispred_cnt    out  32  mispredict count
// BEHAVIOUR
//  - Reset (RSTn=0, async): all counters = CNT_INIT; branch_cnt = mispred_cnt = 0; state = RUN.
//    All outputs are 0 during reset.
//  - Table index: pc[IDX+1:2].
//  - Prediction: id_pred_taken = id_valid & id_is_btype & ctr[idx][1]. Combinational, 0-cycle latency.
//  - ex_fire = ex_valid & ex_is_btype & ~stall & (state==RUN).
//    mispred = ex_fire & (ex_taken != ex_pred_taken).
//  - EX redirect (mispred): redirect_valid=1, flush_ifid=1, flush_idex=1.
//    redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2^32).
//  - ID redirect (id_pred_taken & ~stall & ~mispred & state==RUN):
//    redirect_valid=1, redirect_pc=id_target, flush_ifid=1, flush_idex=0.
//  - Priority: EX redirect always beats ID redirect in the same cycle.
//  - FSM: RUN --mispred--> SQUASH (1 cycle) --> RUN.
//    In SQUASH, ex_valid/id_valid are ignored: no redirect, no training, no count.
//    This protects against a late or unflushed bubble.
//  - Training on ex_fire, next edge: ctr[ex idx] +1 if ex_taken else -1, saturating at 00/11.
//    branch_cnt += 1; mispred_cnt += mispred. Counters wrap 0xFFFFFFFF -> 0.
//  - Same index read in ID and written from EX in one cycle: ID sees the pre-update value (read-before-write).
//  - stall=1: no training, no count, no redirect, no flush. id_pred_taken is still driven.
//  - Non-B-type or invalid in EX: no effect on any state.
//  - Reset mid-operation (incl. in SQUASH): immediate return to reset state; no pending redirect survives.
// STRUCTURE
//  - Shared package: BHT counter encodings (SNT=00, WNT=01, WT=10, ST=11); FSM state enum {RUN, SQUASH}.
//  - Sub-module bht_2bit: counter array with 1 combinational read port (ID) and 1 synchronous
//    saturating-update port (EX), async reset to CNT_INIT.
//  - Top level holds the FSM, redirect mux, flush logic and performance counters.
// TESTING
//  1. Reset: RSTn=0 -> all outputs 0; after release, any B-type in ID at any pc -> id_pred_taken=0.
//  2. Training: 2 taken resolves at ex_pc=0x40 -> ctr 01->10->11; then id_pc=0x40 -> id_pred_taken=1, redirect_pc=id_target.
//  3. Mispredict: ex_pred_taken=0, ex_taken=1, ex_target=0x100 -> same-cycle redirect_valid=1, redirect_pc=0x100,
//     both flushes; next cycle with ex_valid=1 -> no action; mispred_cnt=1.
//  4. Collision: EX mispred and ID predict-taken same cycle -> redirect_pc=EX value, flush_idex=1.
//     Same index ID/EX -> ID uses old counter.
//  5. Stall: stall=1 with a mispredicting branch in EX for 3 cycles -> no redirect, counters unchanged;
//     stall drops -> exactly one redirect, branch_cnt +1.
//  6. Reset mid-SQUASH and counter wrap: RSTn pulse in SQUASH -> RUN, counts 0;
//     force branch_cnt=0xFFFFFFFF, one resolve -> 0.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings, FSM states
// and the saturating counter step used by the BHT.
package branch_predict_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  // Saturating +1 / -1 on a 2-bit direction counter
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != ST) r = c + 2'd1;
    end else begin
      if (c != SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Pipeline <-> branch controller bundle. master = pipeline side, slave = controller.
interface branch_predict_ctrl_if
  import branch_predict_ctrl_pkg::*;
  ();
  logic            stall;
  logic            id_valid;
  logic            id_is_btype;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_target;
  logic            id_pred_taken;
  logic            ex_valid;
  logic            ex_is_btype;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_taken;
  logic            ex_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic [XLEN-1:0] branch_cnt;
  logic [XLEN-1:0] mispred_cnt;

  modport master (
    output stall, id_valid, id_is_btype, id_pc, id_target,
           ex_valid, ex_is_btype, ex_pc, ex_target, ex_taken, ex_pred_taken,
    input  id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, id_valid, id_is_btype, id_pc, id_target,
           ex_valid, ex_is_btype, ex_pc, ex_target, ex_taken, ex_pred_taken,
    output id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_ctrl_bht.sv
// 2-bit saturating counter table: one combinational read port (ID) and one
// synchronous update port (EX). Reads return the pre-update value.
module bht_2bit
  import branch_predict_ctrl_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter int         IDX      = $clog2(ENTRIES),
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDX-1:0] rd_idx,
  output logic [1:0]     rd_ctr,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken
);

  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;

  // Next-state table: only the trained entry moves
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = ctr_step(ctr_q[wr_idx], wr_taken);
  end

  // Table state, every entry back to CNT_INIT on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= {ENTRIES{CNT_INIT}};
    else        ctr_q <= ctr_d;
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Conditional-branch direction predictor and redirect/flush sequencer.
// ID predicts from the BHT and redirects on predict-taken; EX resolves,
// redirects on mispredict, trains the BHT and counts branches/mispredicts.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_INIT    = 1
) (
  input  logic                CLK,
  input  logic                RSTn,
  branch_predict_ctrl_if.slave bus
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  state_e          state_q, state_d;
  logic [XLEN-1:0] branch_cnt_q, branch_cnt_d;
  logic [XLEN-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]  id_idx, ex_idx;
  logic [1:0]      id_ctr;
  logic            id_pred;
  logic            ex_fire, mispred, id_redir;
  logic            redir_v, fl_ifid, fl_idex;
  logic [XLEN-1:0] redir_pc;

  assign id_idx = bus.id_pc[IDX+1:2];
  assign ex_idx = bus.ex_pc[IDX+1:2];

  bht_2bit #(
    .ENTRIES  (BHT_ENTRIES),
    .IDX      (IDX),
    .CNT_INIT (2'(CNT_INIT))
  ) u_bht (
    .clk      (CLK),
    .rst_n    (RSTn),
    .rd_idx   (id_idx),
    .rd_ctr   (id_ctr),
    .wr_en    (ex_fire),
    .wr_idx   (ex_idx),
    .wr_taken (bus.ex_taken)
  );

  // Prediction is not gated by stall or FSM state; it still follows the pipe
  assign id_pred  = RSTn & bus.id_valid & bus.id_is_btype & id_ctr[1];
  assign ex_fire  = RSTn & bus.ex_valid & bus.ex_is_btype & ~bus.stall & (state_q == RUN);
  assign mispred  = ex_fire & (bus.ex_taken != bus.ex_pred_taken);
  assign id_redir = id_pred & ~bus.stall & ~mispred & (state_q == RUN);

  // Redirect mux: EX mispredict outranks an ID predict-taken in the same cycle.
  // redirect_pc is held at 0 when no redirect is requested.
  always_comb begin
    redir_v  = 1'b0;
    redir_pc = '0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    if (mispred) begin
      redir_v  = 1'b1;
      redir_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
      fl_ifid  = 1'b1;
      fl_idex  = 1'b1;
    end else if (id_redir) begin
      redir_v  = 1'b1;
      redir_pc = bus.id_target;
      fl_ifid  = 1'b1;
    end
  end

  // Next state: one SQUASH cycle after every mispredict; counters on resolve
  always_comb begin
    state_d       = mispred ? SQUASH : RUN;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_fire) branch_cnt_d  = branch_cnt_q + 32'd1;
    if (mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // FSM and performance counters
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= RUN;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.id_pred_taken  = id_pred;
  assign bus.redirect_valid = redir_v;
  assign bus.redirect_pc    = redir_pc;
  assign bus.flush_ifid     = fl_ifid;
  assign bus.flush_idex     = fl_idex;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: stimulus pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
module tb_branch_predict_ctrl;

  logic clk;
  logic rst_n;

  branch_predict_ctrl_if bus ();

  branch_predict_ctrl #(.BHT_ENTRIES(16), .CNT_INIT(1)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pred;
    logic        rv;
    logic [31:0] rpc;
    logic        fi;
    logic        fe;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk({mon_e.tag, ".pred"}, 32'(bus.id_pred_taken),  32'(mon_e.pred));
        chk({mon_e.tag, ".rv"},   32'(bus.redirect_valid), 32'(mon_e.rv));
        chk({mon_e.tag, ".rpc"},  bus.redirect_pc,         mon_e.rpc);
        chk({mon_e.tag, ".fi"},   32'(bus.flush_ifid),     32'(mon_e.fi));
        chk({mon_e.tag, ".fe"},   32'(bus.flush_idex),     32'(mon_e.fe));
        chk({mon_e.tag, ".bc"},   bus.branch_cnt,          mon_e.bc);
        chk({mon_e.tag, ".mc"},   bus.mispred_cnt,         mon_e.mc);
      end
    end
  end

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] tgt);
    bus.id_valid    = v;
    bus.id_is_btype = v;
    bus.id_pc       = pc;
    bus.id_target   = tgt;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic pt);
    bus.ex_valid      = v;
    bus.ex_is_btype   = v;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.ex_taken      = tk;
    bus.ex_pred_taken = pt;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic pred, input logic rv, input logic [31:0] rpc,
                     input logic fi, input logic fe, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.tag = tag; e.pred = pred; e.rv = rv; e.rpc = rpc;
    e.fi = fi; e.fe = fe; e.bc = bc; e.mc = mc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    set_id(1'b1, 32'h40, 32'h80);
    set_ex(1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    // Reset: everything 0 even with live inputs
    cyc("rst0", 0, 0, 32'h0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fresh table predicts not-taken everywhere
    set_id(1'b1, 32'h0,    32'h10);   cyc("t1a", 0, 0, 32'h0, 0, 0, 0, 0);
    set_id(1'b1, 32'h44,   32'h90);   cyc("t1b", 0, 0, 32'h0, 0, 0, 0, 0);
    set_id(1'b1, 32'h1234, 32'h2000); cyc("t1c", 0, 0, 32'h0, 0, 0, 0, 0);

    // Training at 0x40: 01 -> 10 -> 11, then ID predict-taken redirect
    set_id(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h40, 32'h200, 1'b1, 1'b1);
    cyc("t2a", 0, 0, 32'h0, 0, 0, 0, 0);
    cyc("t2b", 0, 0, 32'h0, 0, 0, 1, 0);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_id(1'b1, 32'h40, 32'h80);
    cyc("t2c", 1, 1, 32'h80, 1, 0, 2, 0);

    // Mispredict taken -> target; SQUASH ignores the held EX branch
    set_id(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h204, 32'h100, 1'b1, 1'b0);
    cyc("t3a", 0, 1, 32'h100, 1, 1, 2, 0);
    cyc("t3b", 0, 0, 32'h0, 0, 0, 3, 1);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("t3c", 0, 0, 32'h0, 0, 0, 3, 1);
    // Mispredict not-taken -> pc+4 (ctr[0] 11 -> 10)
    set_ex(1'b1, 32'h300, 32'h500, 1'b0, 1'b1);
    cyc("t3d", 0, 1, 32'h304, 1, 1, 3, 1);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("t3e", 0, 0, 32'h0, 0, 0, 4, 2);

    // Collision, same index: ID reads old 10 (taken), EX redirect wins
    set_id(1'b1, 32'h40, 32'h80);
    set_ex(1'b1, 32'h40, 32'h900, 1'b0, 1'b1);
    cyc("t4a", 1, 1, 32'h44, 1, 1, 4, 2);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("t4b", 0, 0, 32'h0, 0, 0, 5, 3);
    set_id(1'b0, 32'h0, 32'h0);
    cyc("t4c", 0, 0, 32'h0, 0, 0, 5, 3);

    // Stall holds a mispredicting branch; prediction still driven
    bus.stall = 1'b1;
    set_id(1'b1, 32'h44, 32'h500);
    set_ex(1'b1, 32'h208, 32'h400, 1'b1, 1'b0);
    cyc("t5s0", 1, 0, 32'h0, 0, 0, 5, 3);
    cyc("t5s1", 1, 0, 32'h0, 0, 0, 5, 3);
    cyc("t5s2", 1, 0, 32'h0, 0, 0, 5, 3);
    bus.stall = 1'b0;
    set_id(1'b0, 32'h0, 32'h0);
    cyc("t5a", 0, 1, 32'h400, 1, 1, 5, 3);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_id(1'b1, 32'h44, 32'h500);
    cyc("t5b", 1, 0, 32'h0, 0, 0, 6, 4);
    cyc("t5c", 1, 1, 32'h500, 1, 0, 6, 4);

    // Reset pulse while in SQUASH
    set_id(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h20c, 32'h600, 1'b1, 1'b0);
    cyc("t6a", 0, 1, 32'h600, 1, 1, 6, 4);
    rst_n = 1'b0;
    cyc("t6r", 0, 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    set_id(1'b1, 32'h44, 32'h500);
    cyc("t6b", 0, 1, 32'h600, 1, 1, 0, 0);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_id(1'b0, 32'h0, 32'h0);
    cyc("t6c", 0, 0, 32'h0, 0, 0, 1, 1);

    // Branch counter wrap
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    set_ex(1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
    cyc("t6w", 0, 0, 32'h0, 0, 0, 32'hFFFF_FFFF, 1);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("t6x", 0, 0, 32'h0, 0, 0, 32'h0, 1);

    @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
